encoder_ctrl: RTL and testbench

Control unit that sequences the 1600-bit encoder datapath through 24 rounds. Per round it runs, in order: column parity, rotate, permute, revaluate and add-round-constant, then feeds the result back into memory. It sits beside the encoder datapath and drives every load, save, round, reset and start strobe from one top-level start/done handshake. It adds a per-stage watchdog that flags a hung sub-block.

---
 rtl/encoder_ctrl_pkg.sv | 33 +++
 rtl/ctrl_watchdog.sv | 34 +++
 rtl/encoder_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_encoder_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_ctrl_pkg.sv
// Shared definitions for the encoder round controller.
//   state_t      : controller states; RST/GO/WAIT are shared by all five
//                  stages and qualified by the current stage index
//   stage_t      : stage index, CP = 0 .. RC = 4
//   ROUNDS       : number of encoder rounds per start
//   LAST_ROUND   : round_dbg value expected at the final CHECK
package encoder_ctrl_pkg;

  localparam int ROUNDS = 24;
  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_INIT  = 4'd1,
    S_LOAD  = 4'd2,
    S_RST   = 4'd3,
    S_GO    = 4'd4,
    S_WAIT  = 4'd5,
    S_CHECK = 4'd6,
    S_FEED  = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    STG_CP = 3'd0,
    STG_RT = 3'd1,
    STG_PR = 3'd2,
    STG_RV = 3'd3,
    STG_RC = 3'd4
  } stage_t;

endpackage

// File: rtl/ctrl_watchdog.sv
// Per-stage watchdog counter.
//   clk, reset : system clock, async active-low reset
//   clr        : restart the count at zero (takes priority over en)
//   en         : count one waiting cycle
//   tc         : high during the WAIT_LIMIT-th enabled cycle after clr;
//                the count saturates there
module ctrl_watchdog #(
  parameter int WAIT_LIMIT = 4095,
  parameter int WCNT_W     = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WCNT_W-1:0] cnt;

  // The count holds the number of cycles already waited, so it equals
  // WAIT_LIMIT-1 while the last permitted waiting cycle is in progress.
  assign tc = (cnt == WCNT_W'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/encoder_ctrl.sv
// Round sequencer for the 1600-bit encoder datapath.
// Runs 24 rounds of CP -> RT -> PR -> RV -> RC per start, feeding each
// result back into memory, with a watchdog on every stage wait.
//   clk, reset         : system clock, async active-low reset
//   start              : begin encoding (honoured in IDLE and ERR only)
//   completed          : round counter carry from the datapath
//   cp_Ready .. rc_done: per-stage finished flags
//   sel/load/save      : memory source select and strobes
//   next_round, r_rst  : round counter increment / reset
//   *_rst, *_start     : per-stage reset and start strobes
//   busy, done, error  : status; round_dbg mirrors the current round
//
// state | meaning
// IDLE  | waiting for start
// INIT  | reset round counter and all stages, round_dbg := 0
// LOAD  | load memory from raw_data (sel = 0)
// RST   | reset the current stage
// GO    | start the current stage, clear watchdog
// WAIT  | wait for the current stage's ready/done, watchdog running
// CHECK | decide between another round, DONE or ERR
// FEED  | feed result back (sel = 1), bump round
// DONE  | done + save pulse
// ERR   | watchdog or round consistency failure, wait for start
module encoder_ctrl
  import encoder_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 4095,
  parameter int WCNT_W     = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       completed,
  input  logic       cp_Ready,
  input  logic       rt_Ready,
  input  logic       pr_done,
  input  logic       rv_done,
  input  logic       rc_done,
  output logic       sel,
  output logic       load,
  output logic       save,
  output logic       next_round,
  output logic       r_rst,
  output logic       cp_rst,
  output logic       rt_rst,
  output logic       pr_rst,
  output logic       rv_rst,
  output logic       rc_rst,
  output logic       cp_start,
  output logic       rt_start,
  output logic       pr_start,
  output logic       rv_start,
  output logic       rc_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] round_dbg
);

  state_t     state_q, state_d;
  stage_t     stg_q, stg_d;
  logic [4:0] round_d;
  logic [4:0] stage_dones;
  logic       stage_done;
  logic       wd_tc;

  logic       sel_d, load_d, save_d, next_round_d, r_rst_d;
  logic       busy_d, done_d, error_d;
  logic [4:0] stg_hot;
  logic [4:0] srst_d, sstart_d, srst_q, sstart_q;

  assign stage_dones = {rc_done, rv_done, pr_done, rt_Ready, cp_Ready};
  assign stage_done  = stage_dones[stg_q];

  ctrl_watchdog #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .WCNT_W     (WCNT_W)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == S_GO),
    .en    (state_q == S_WAIT),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      stg_q   <= STG_CP;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_RST;
        stg_d   = STG_CP;
      end
      S_RST:   state_d = S_GO;
      S_GO:    state_d = S_WAIT;
      S_WAIT: begin
        // A stage that finishes on its last permitted cycle is accepted.
        if (stage_done) begin
          if (stg_q == STG_RC) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_RST;
            stg_d   = stage_t'(stg_q + 3'd1);
          end
        end else if (wd_tc) begin
          state_d = S_ERR;
        end
      end
      S_CHECK: begin
        if (completed) begin
          state_d = (round_dbg == LAST_ROUND) ? S_DONE : S_ERR;
        end else begin
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        state_d = S_RST;
        stg_d   = STG_CP;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   if (start) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each
  // strobe is high exactly while the controller sits in its state.
  always_comb begin
    load_d       = 1'b0;
    save_d       = 1'b0;
    next_round_d = 1'b0;
    r_rst_d      = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    srst_d       = '0;
    sstart_d     = '0;
    round_d      = round_dbg;
    stg_hot      = 5'b00001 << stg_d;
    case (state_d)
      S_INIT: begin
        r_rst_d = 1'b1;
        srst_d  = 5'b11111;
        round_d = '0;
      end
      S_LOAD:  load_d   = 1'b1;
      S_RST:   srst_d   = stg_hot;
      S_GO:    sstart_d = stg_hot;
      S_FEED: begin
        next_round_d = 1'b1;
        load_d       = 1'b1;
        round_d      = round_dbg + 5'd1;
      end
      S_DONE: begin
        done_d = 1'b1;
        save_d = 1'b1;
      end
      S_ERR:   error_d = 1'b1;
      default: ;
    endcase
    sel_d  = !(state_d inside {S_IDLE, S_INIT, S_LOAD});
    busy_d = !(state_d inside {S_IDLE, S_ERR});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel        <= 1'b0;
      load       <= 1'b0;
      save       <= 1'b0;
      next_round <= 1'b0;
      r_rst      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      srst_q     <= '0;
      sstart_q   <= '0;
      round_dbg  <= '0;
    end else begin
      sel        <= sel_d;
      load       <= load_d;
      save       <= save_d;
      next_round <= next_round_d;
      r_rst      <= r_rst_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      srst_q     <= srst_d;
      sstart_q   <= sstart_d;
      round_dbg  <= round_d;
    end
  end

  assign cp_rst   = srst_q[STG_CP];
  assign rt_rst   = srst_q[STG_RT];
  assign pr_rst   = srst_q[STG_PR];
  assign rv_rst   = srst_q[STG_RV];
  assign rc_rst   = srst_q[STG_RC];
  assign cp_start = sstart_q[STG_CP];
  assign rt_start = sstart_q[STG_RT];
  assign pr_start = sstart_q[STG_PR];
  assign rv_start = sstart_q[STG_RV];
  assign rc_start = sstart_q[STG_RC];

endmodule

// File: tb/tb_encoder_ctrl.sv
// Self-checking bench for encoder_ctrl. A behavioural datapath model answers
// each stage start after a random 1..3 cycle latency, keeps its own round
// counter for completed, and tallies the cycle cost of every stage
// (reset + start + waiting cycles) so the total run length can be predicted.
module tb_encoder_ctrl;

  localparam int WL     = 16;
  localparam int NR     = 24;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic completed;
  logic cp_Ready, rt_Ready, pr_done, rv_done, rc_done;
  logic sel, load, save, next_round, r_rst;
  logic cp_rst, rt_rst, pr_rst, rv_rst, rc_rst;
  logic cp_start, rt_start, pr_start, rv_start, rc_start;
  logic busy, done, error;
  logic [4:0] round_dbg;
  logic [17:0] outs;

  int n_pass = 0;
  int n_chk  = 0;

  // datapath model and monitor state
  int       rnd = 0;
  int       dly [5];
  bit [4:0] dn;
  bit       stale_cp;
  int       hang_round = -1;
  int       force_round = -1;
  int       cyc = 0;
  int       stage_sum = 0;
  int       n_cp_start, n_next_round, n_done, n_save, n_load, n_load_sel0;
  int       n_init = 0, n_cp_bad;
  int       init_cyc, done_cyc, pr_start_cyc, err_cyc, cp_rst_cyc;
  bit       err_seen;
  logic [4:0] st_v, rs_v;

  always #5 clk = ~clk;

  assign completed = (rnd == NR - 1) || (rnd == force_round);
  assign cp_Ready  = dn[0] | stale_cp;
  assign rt_Ready  = dn[1];
  assign pr_done   = dn[2];
  assign rv_done   = dn[3];
  assign rc_done   = dn[4];
  assign outs = {sel, load, save, next_round, r_rst, cp_rst, rt_rst, pr_rst, rv_rst, rc_rst,
                 cp_start, rt_start, pr_start, rv_start, rc_start, busy, done, error};

  encoder_ctrl #(.WAIT_LIMIT(WL), .WCNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .completed  (completed),
    .cp_Ready   (cp_Ready),
    .rt_Ready   (rt_Ready),
    .pr_done    (pr_done),
    .rv_done    (rv_done),
    .rc_done    (rc_done),
    .sel        (sel),
    .load       (load),
    .save       (save),
    .next_round (next_round),
    .r_rst      (r_rst),
    .cp_rst     (cp_rst),
    .rt_rst     (rt_rst),
    .pr_rst     (pr_rst),
    .rv_rst     (rv_rst),
    .rc_rst     (rc_rst),
    .cp_start   (cp_start),
    .rt_start   (rt_start),
    .pr_start   (pr_start),
    .rv_start   (rv_start),
    .rc_start   (rc_start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .round_dbg  (round_dbg)
  );

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rnd = 0;
      dn  = '0;
      for (int s = 0; s < 5; s++) dly[s] = 0;
    end else begin
      cyc++;
      st_v = {rc_start, rv_start, pr_start, rt_start, cp_start};
      rs_v = {rc_rst, rv_rst, pr_rst, rt_rst, cp_rst};
      if (r_rst) begin
        rnd = 0; stage_sum = 0; init_cyc = cyc; n_init++;
        n_cp_start = 0; n_next_round = 0; n_done = 0; n_save = 0;
        n_load = 0; n_load_sel0 = 0; n_cp_bad = 0; err_seen = 0;
      end
      if (next_round) begin rnd++; n_next_round++; end
      if (cp_start) n_cp_start++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (save) n_save++;
      if (load) begin n_load++; if (!sel) n_load_sel0++; end
      if (pr_start) pr_start_cyc = cyc;
      if (error && !err_seen) begin err_seen = 1; err_cyc = cyc; end
      if (cp_rst && !r_rst) cp_rst_cyc = cyc;
      if (rt_rst && !r_rst && stale_cp && (cyc - cp_rst_cyc != 3)) n_cp_bad++;
      for (int s = 0; s < 5; s++) begin
        if (rs_v[s]) begin
          dn[s] = 1'b0; dly[s] = 0;
        end else if (st_v[s]) begin
          if (s == 2 && rnd == hang_round) begin
            dly[s] = 0;
          end else begin
            int lat;
            lat = int'($urandom_range(1, 3));
            dly[s] = lat;
            stage_sum += 2 + ((s == 0 && stale_cp) ? 1 : lat);
          end
        end else if (dly[s] > 0) begin
          dly[s]--;
          if (dly[s] == 0) dn[s] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Leaves the DUT observed in its INIT cycle.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (done === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic wait_error(output bit ok);
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (error === 1'b1) begin ok = 1; break; end
    end
  endtask

  function automatic int run_len();
    // INIT + LOAD + all stages + 24 CHECKs + 23 FEEDs
    return 2 + stage_sum + NR + (NR - 1);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    n_chk++; if (outs !== '0) $display("FAIL reset_outs: got %h want 0", outs); else n_pass++;
    n_chk++; if (round_dbg !== 5'd0) $display("FAIL reset_round: got %0d want 0", round_dbg); else n_pass++;
    start = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    n_chk++; if (outs !== '0) $display("FAIL idle_outs: got %h want 0", outs); else n_pass++;
  endtask

  task automatic test_nominal();
    bit ok;
    launch();
    n_chk++; if (r_rst !== 1'b1 || busy !== 1'b1) $display("FAIL nom_init: r_rst=%b busy=%b want 1 1", r_rst, busy); else n_pass++;
    tick();
    n_chk++; if (load !== 1'b1 || sel !== 1'b0) $display("FAIL nom_first_load: load=%b sel=%b want 1 0", load, sel); else n_pass++;
    wait_done(ok);
    n_chk++; if (!ok) $display("FAIL nom_done_timeout: no done within %0d cycles", BUDGET); else n_pass++;
    n_chk++; if (save !== 1'b1) $display("FAIL nom_save_with_done: got %b want 1", save); else n_pass++;
    n_chk++; if (round_dbg !== 5'd23) $display("FAIL nom_last_round: got %0d want 23", round_dbg); else n_pass++;
    n_chk++; if (done_cyc - init_cyc != run_len()) $display("FAIL nom_run_length: got %0d want %0d", done_cyc - init_cyc, run_len()); else n_pass++;
    n_chk++; if (n_cp_start != NR) $display("FAIL nom_cp_starts: got %0d want %0d", n_cp_start, NR); else n_pass++;
    n_chk++; if (n_next_round != NR - 1) $display("FAIL nom_next_rounds: got %0d want %0d", n_next_round, NR - 1); else n_pass++;
    n_chk++; if (n_load != NR || n_load_sel0 != 1) $display("FAIL nom_loads: got %0d loads %0d with sel=0, want %0d and 1", n_load, n_load_sel0, NR); else n_pass++;
    repeat (3) tick();
    n_chk++; if (n_done != 1 || n_save != 1) $display("FAIL nom_pulse_counts: done=%0d save=%0d want 1 1", n_done, n_save); else n_pass++;
    n_chk++; if (busy !== 1'b0 || sel !== 1'b0) $display("FAIL nom_back_idle: busy=%b sel=%b want 0 0", busy, sel); else n_pass++;
  endtask

  task automatic test_stale_ready();
    bit ok;
    stale_cp = 1'b1;
    launch();
    wait_done(ok);
    n_chk++; if (!ok) $display("FAIL stale_done_timeout: no done within %0d cycles", BUDGET); else n_pass++;
    n_chk++; if (n_cp_bad != 0) $display("FAIL stale_cp_stage_len: %0d CP stages not 3 cycles, want 0", n_cp_bad); else n_pass++;
    n_chk++; if (n_cp_start != NR) $display("FAIL stale_cp_starts: got %0d want %0d", n_cp_start, NR); else n_pass++;
    n_chk++; if (done_cyc - init_cyc != run_len()) $display("FAIL stale_run_length: got %0d want %0d", done_cyc - init_cyc, run_len()); else n_pass++;
    tick();
    stale_cp = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok, pulsed;
    int n0;
    n0 = n_init;
    launch();
    ok = 0; pulsed = 0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      start = 1'b0;
      if (!pulsed && round_dbg == 5'd3 && cp_start) begin start = 1'b1; pulsed = 1; end
      if (done === 1'b1) begin ok = 1; start = 1'b1; break; end
    end
    tick();
    start = 1'b0;
    n_chk++; if (!ok || !pulsed) $display("FAIL b2b_done_timeout: done=%b pulsed=%b want 1 1", ok, pulsed); else n_pass++;
    n_chk++; if (busy !== 1'b0 || r_rst !== 1'b0) $display("FAIL b2b_after_done: busy=%b r_rst=%b want 0 0", busy, r_rst); else n_pass++;
    repeat (4) tick();
    n_chk++; if (n_init != n0 + 1) $display("FAIL b2b_restarts: got %0d INITs want 1", n_init - n0); else n_pass++;
    n_chk++; if (n_done != 1 || n_next_round != NR - 1) $display("FAIL b2b_counts: done=%0d feeds=%0d want 1 %0d", n_done, n_next_round, NR - 1); else n_pass++;
    n_chk++; if (done_cyc - init_cyc != run_len()) $display("FAIL b2b_run_length: got %0d want %0d", done_cyc - init_cyc, run_len()); else n_pass++;
  endtask

  task automatic test_watchdog();
    bit ok;
    hang_round = 5;
    launch();
    wait_error(ok);
    n_chk++; if (!ok) $display("FAIL wd_timeout: no error within %0d cycles", BUDGET); else n_pass++;
    // 16 waiting cycles follow the pr_start cycle, ERR is the next one
    n_chk++; if (err_cyc - pr_start_cyc != WL + 1) $display("FAIL wd_latency: got %0d want %0d", err_cyc - pr_start_cyc, WL + 1); else n_pass++;
    n_chk++; if (busy !== 1'b0 || round_dbg !== 5'd5) $display("FAIL wd_status: busy=%b round=%0d want 0 5", busy, round_dbg); else n_pass++;
    repeat (3) tick();
    n_chk++; if (error !== 1'b1 || n_done != 0) $display("FAIL wd_err_held: error=%b dones=%0d want 1 0", error, n_done); else n_pass++;
    hang_round = -1;
    launch();
    n_chk++; if (r_rst !== 1'b1 || error !== 1'b0 || round_dbg !== 5'd0 || busy !== 1'b1)
      $display("FAIL wd_restart: r_rst=%b error=%b round=%0d busy=%b want 1 0 0 1", r_rst, error, round_dbg, busy); else n_pass++;
    wait_done(ok);
    n_chk++; if (!ok || round_dbg !== 5'd23) $display("FAIL wd_rerun: done=%b round=%0d want 1 23", ok, round_dbg); else n_pass++;
    tick();
  endtask

  task automatic test_midrun_reset();
    bit ok;
    launch();
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (round_dbg == 5'd10 && rv_start) begin ok = 1; break; end
    end
    n_chk++; if (!ok) $display("FAIL mr_reach_rv10: rv_start of round 10 not seen within %0d cycles", BUDGET); else n_pass++;
    tick();
    #2 reset = 1'b0;
    #1;
    n_chk++; if (outs !== '0 || round_dbg !== 5'd0) $display("FAIL mr_async_clear: outs=%h round=%0d want 0 0", outs, round_dbg); else n_pass++;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    n_chk++; if (outs !== '0 || n_save != 0) $display("FAIL mr_idle: outs=%h saves=%0d want 0 0", outs, n_save); else n_pass++;
    launch();
    n_chk++; if (r_rst !== 1'b1 || round_dbg !== 5'd0) $display("FAIL mr_restart: r_rst=%b round=%0d want 1 0", r_rst, round_dbg); else n_pass++;
    wait_done(ok);
    n_chk++; if (!ok || done_cyc - init_cyc != run_len()) $display("FAIL mr_rerun: done=%b len=%0d want 1 %0d", ok, done_cyc - init_cyc, run_len()); else n_pass++;
    tick();
  endtask

  task automatic test_early_completed();
    bit ok;
    force_round = 7;
    launch();
    wait_error(ok);
    n_chk++; if (!ok) $display("FAIL early_no_err: no error within %0d cycles", BUDGET); else n_pass++;
    n_chk++; if (round_dbg !== 5'd7 || n_done != 0 || n_save != 0)
      $display("FAIL early_status: round=%0d dones=%0d saves=%0d want 7 0 0", round_dbg, n_done, n_save); else n_pass++;
    force_round = -1;
    repeat (2) tick();
    n_chk++; if (error !== 1'b1 || busy !== 1'b0) $display("FAIL early_err_held: error=%b busy=%b want 1 0", error, busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stale_ready();
    test_back_to_back();
    test_watchdog();
    test_midrun_reset();
    test_early_completed();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
